// File: rtl/tennis_score_keeper.sv
// Tennis set scorekeeper: tracks points and games for players A and B from single-cycle point pulses.
// All outputs are registered. A point pulse sampled at an edge is visible right after that edge.
module tennis_score_keeper #(
    parameter int GAMES_TO_WIN = 6,
    parameter int GAMES_MAX    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pt_a,
    input  logic       pt_b,
    input  logic       new_set,
    output logic [2:0] score_a,
    output logic [2:0] score_b,
    output logic [2:0] games_a,
    output logic [2:0] games_b,
    output logic       deuce,
    output logic       game_a,
    output logic       game_b,
    output logic       set_done,
    output logic       set_winner,
    output logic       collision
);

    typedef enum logic {
        S_PLAY     = 1'b0,
        S_SET_OVER = 1'b1
    } state_t;

    localparam logic [3:0] L_GAMES_TO_WIN = 4'(GAMES_TO_WIN);
    localparam logic [3:0] L_GAMES_MAX    = 4'(GAMES_MAX);

    localparam logic [2:0] PT_LOVE = 3'd0;
    localparam logic [2:0] PT_40   = 3'd3;
    localparam logic [2:0] PT_AD   = 3'd4;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_score_a, r_score_b, w_score_a_nxt, w_score_b_nxt;
    logic [2:0] r_games_a, r_games_b, w_games_a_nxt, w_games_b_nxt;
    logic       r_deuce, w_deuce_nxt;
    logic       r_game_a, r_game_b, w_game_a_nxt, w_game_b_nxt;
    logic       r_set_winner, w_set_winner_nxt;
    logic       r_collision, w_collision_nxt;

    // Scoring is computed once from the point winner's perspective, then mapped back to A/B.
    logic [2:0] w_win_score, w_los_score;
    logic [2:0] w_win_score_nxt, w_los_score_nxt;
    logic [3:0] w_win_games_inc, w_los_games;
    logic       w_game_won, w_set_won, w_score_bad;

    assign w_win_score     = pt_a ? r_score_a : r_score_b;
    assign w_los_score     = pt_a ? r_score_b : r_score_a;
    assign w_win_games_inc = {1'b0, (pt_a ? r_games_a : r_games_b)} + 4'd1;
    assign w_los_games     = {1'b0, (pt_a ? r_games_b : r_games_a)};
    assign w_score_bad     = (r_score_a > PT_AD) || (r_score_b > PT_AD);

    always_comb begin
        w_win_score_nxt = w_win_score;
        w_los_score_nxt = w_los_score;
        w_game_won      = 1'b0;
        if (w_win_score < PT_40) begin
            w_win_score_nxt = w_win_score + 3'd1;
        end else if (w_win_score == PT_40 && w_los_score < PT_40) begin
            w_game_won = 1'b1;
        end else if (w_win_score == PT_40 && w_los_score == PT_40) begin
            w_win_score_nxt = PT_AD;
        end else if (w_win_score == PT_AD) begin
            w_game_won = 1'b1;
        end else if (w_win_score == PT_40 && w_los_score == PT_AD) begin
            w_los_score_nxt = PT_40;
        end
    end

    // Set check uses the winner's game count after this game is added.
    assign w_set_won = w_game_won &&
                       ((w_win_games_inc == L_GAMES_MAX) ||
                        ((w_win_games_inc >= L_GAMES_TO_WIN) &&
                         (w_win_games_inc >= w_los_games + 4'd2)));

    always_comb begin
        w_state_nxt      = r_state;
        w_score_a_nxt    = r_score_a;
        w_score_b_nxt    = r_score_b;
        w_games_a_nxt    = r_games_a;
        w_games_b_nxt    = r_games_b;
        w_game_a_nxt     = 1'b0;
        w_game_b_nxt     = 1'b0;
        w_set_winner_nxt = r_set_winner;
        w_collision_nxt  = 1'b0;

        if (new_set) begin
            w_state_nxt      = S_PLAY;
            w_score_a_nxt    = PT_LOVE;
            w_score_b_nxt    = PT_LOVE;
            w_games_a_nxt    = 3'd0;
            w_games_b_nxt    = 3'd0;
            w_set_winner_nxt = 1'b0;
        end else if (w_score_bad) begin
            w_score_a_nxt = PT_LOVE;
            w_score_b_nxt = PT_LOVE;
        end else if (r_state == S_PLAY) begin
            if (pt_a && pt_b) begin
                w_collision_nxt = 1'b1;
            end else if (pt_a || pt_b) begin
                if (w_game_won) begin
                    w_score_a_nxt = PT_LOVE;
                    w_score_b_nxt = PT_LOVE;
                    if (pt_a) begin
                        w_games_a_nxt = w_win_games_inc[2:0];
                        w_game_a_nxt  = 1'b1;
                    end else begin
                        w_games_b_nxt = w_win_games_inc[2:0];
                        w_game_b_nxt  = 1'b1;
                    end
                    if (w_set_won) begin
                        w_state_nxt      = S_SET_OVER;
                        w_set_winner_nxt = pt_b;
                    end
                end else if (pt_a) begin
                    w_score_a_nxt = w_win_score_nxt;
                    w_score_b_nxt = w_los_score_nxt;
                end else begin
                    w_score_b_nxt = w_win_score_nxt;
                    w_score_a_nxt = w_los_score_nxt;
                end
            end
        end

        w_deuce_nxt = (w_score_a_nxt == PT_40) && (w_score_b_nxt == PT_40);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_PLAY;
            r_score_a    <= PT_LOVE;
            r_score_b    <= PT_LOVE;
            r_games_a    <= 3'd0;
            r_games_b    <= 3'd0;
            r_deuce      <= 1'b0;
            r_game_a     <= 1'b0;
            r_game_b     <= 1'b0;
            r_set_winner <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_score_a    <= w_score_a_nxt;
            r_score_b    <= w_score_b_nxt;
            r_games_a    <= w_games_a_nxt;
            r_games_b    <= w_games_b_nxt;
            r_deuce      <= w_deuce_nxt;
            r_game_a     <= w_game_a_nxt;
            r_game_b     <= w_game_b_nxt;
            r_set_winner <= w_set_winner_nxt;
            r_collision  <= w_collision_nxt;
        end
    end

    assign score_a    = r_score_a;
    assign score_b    = r_score_b;
    assign games_a    = r_games_a;
    assign games_b    = r_games_b;
    assign deuce      = r_deuce;
    assign game_a     = r_game_a;
    assign game_b     = r_game_b;
    assign set_done   = (r_state == S_SET_OVER);
    assign set_winner = r_set_winner;
    assign collision  = r_collision;

endmodule

// File: tb/tb_tennis_score_keeper.sv
// Bench for tennis_score_keeper: directed scenarios plus random play against a point-count model.
module tb_tennis_score_keeper;

    localparam int GTW  = 6;
    localparam int GMAX = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pt_a = 1'b0, pt_b = 1'b0, new_set = 1'b0;
    logic [2:0] score_a, score_b, games_a, games_b;
    logic       deuce, game_a, game_b, set_done, set_winner, collision;

    int checks = 0;
    int failures = 0;

    // Model: raw points won in the current game, games in the set, set status, last-edge pulses.
    int m_na, m_nb, m_ga, m_gb;
    bit m_over, m_win, m_pa, m_pb, m_coll;

    tennis_score_keeper #(.GAMES_TO_WIN(GTW), .GAMES_MAX(GMAX)) dut (
        .clk(clk), .reset(reset), .pt_a(pt_a), .pt_b(pt_b), .new_set(new_set),
        .score_a(score_a), .score_b(score_b), .games_a(games_a), .games_b(games_b),
        .deuce(deuce), .game_a(game_a), .game_b(game_b), .set_done(set_done),
        .set_winner(set_winner), .collision(collision)
    );

    always #5 clk = ~clk;

    function automatic int code_of(int me, int other);
        if (me >= 3 && other >= 3) return (me > other) ? 4 : 3;
        return me;
    endfunction

    task automatic model_clear();
        m_na = 0; m_nb = 0; m_ga = 0; m_gb = 0;
        m_over = 0; m_win = 0; m_pa = 0; m_pb = 0; m_coll = 0;
    endtask

    task automatic model_step(input bit a, input bit b, input bit n);
        m_pa = 0; m_pb = 0; m_coll = 0;
        if (n) begin
            model_clear();
        end else if (!m_over) begin
            if (a && b) begin
                m_coll = 1;
            end else if (a || b) begin
                if (a) m_na++; else m_nb++;
                if (m_na >= 3 && m_na == m_nb) begin m_na = 3; m_nb = 3; end
                if (m_na >= 4 && m_na - m_nb >= 2) begin
                    m_ga++; m_na = 0; m_nb = 0; m_pa = 1;
                    if (m_ga == GMAX || (m_ga >= GTW && m_ga - m_gb >= 2)) begin m_over = 1; m_win = 0; end
                end else if (m_nb >= 4 && m_nb - m_na >= 2) begin
                    m_gb++; m_na = 0; m_nb = 0; m_pb = 1;
                    if (m_gb == GMAX || (m_gb >= GTW && m_gb - m_ga >= 2)) begin m_over = 1; m_win = 1; end
                end
            end
        end
    endtask

    // Inputs are presented for one full cycle; outputs are observed 1 time unit after the edge.
    task automatic drive(input bit a, input bit b, input bit n);
        pt_a = a; pt_b = b; new_set = n;
        @(posedge clk);
        #1;
        pt_a = 1'b0; pt_b = 1'b0; new_set = 1'b0;
        model_step(a, b, n);
    endtask

    task automatic win_game(input bit for_a);
        for (int i = 0; i < 4; i++) drive(for_a, !for_a, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({score_a, score_b} !== 6'd0) begin failures++; $display("FAIL rst_scores got=%0d/%0d want=0/0", score_a, score_b); end
        checks++; if ({games_a, games_b} !== 6'd0) begin failures++; $display("FAIL rst_games got=%0d/%0d want=0/0", games_a, games_b); end
        checks++; if ({deuce, game_a, game_b, set_done, set_winner, collision} !== 6'b0) begin
            failures++; $display("FAIL rst_flags got=%b want=000000", {deuce, game_a, game_b, set_done, set_winner, collision}); end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0);
        checks++; if ({score_a, score_b, games_a, games_b, set_done} !== 13'd0) begin
            failures++; $display("FAIL rst_idle got=%0d/%0d g=%0d/%0d done=%b want all 0", score_a, score_b, games_a, games_b, set_done); end
    endtask

    task automatic test_game();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0);
            checks++; if (score_a !== 3'(i) || game_a !== 1'b0) begin
                failures++; $display("FAIL game_pt%0d score_a=%0d game_a=%b want=%0d/0", i, score_a, game_a, i); end
        end
        drive(1, 0, 0);
        checks++; if (game_a !== 1'b1 || games_a !== 3'd1 || score_a !== 3'd0 || score_b !== 3'd0) begin
            failures++; $display("FAIL game_win game_a=%b games_a=%0d scores=%0d/%0d want=1 1 0/0", game_a, games_a, score_a, score_b); end
        drive(0, 0, 0);
        checks++; if (game_a !== 1'b0 || games_a !== 3'd1) begin
            failures++; $display("FAIL game_pulse_end game_a=%b games_a=%0d want=0 1", game_a, games_a); end
    endtask

    task automatic test_deuce();
        repeat (3) drive(1, 0, 0);
        repeat (3) drive(0, 1, 0);
        checks++; if (score_a !== 3'd3 || score_b !== 3'd3 || deuce !== 1'b1) begin
            failures++; $display("FAIL deuce_reach scores=%0d/%0d deuce=%b want=3/3 1", score_a, score_b, deuce); end
        drive(1, 0, 0);
        checks++; if (score_a !== 3'd4 || score_b !== 3'd3 || deuce !== 1'b0) begin
            failures++; $display("FAIL deuce_adv scores=%0d/%0d deuce=%b want=4/3 0", score_a, score_b, deuce); end
        drive(0, 1, 0);
        checks++; if (score_a !== 3'd3 || score_b !== 3'd3 || deuce !== 1'b1) begin
            failures++; $display("FAIL deuce_back scores=%0d/%0d deuce=%b want=3/3 1", score_a, score_b, deuce); end
        drive(0, 1, 0);
        checks++; if (score_b !== 3'd4 || score_a !== 3'd3 || game_b !== 1'b0) begin
            failures++; $display("FAIL deuce_advb scores=%0d/%0d game_b=%b want=3/4 0", score_a, score_b, game_b); end
        drive(0, 1, 0);
        checks++; if (game_b !== 1'b1 || games_b !== 3'd1 || score_a !== 3'd0 || score_b !== 3'd0 || game_a !== 1'b0) begin
            failures++; $display("FAIL deuce_gameb game_b=%b games_b=%0d scores=%0d/%0d want=1 1 0/0", game_b, games_b, score_a, score_b); end
    endtask

    task automatic test_set_7_5();
        drive(0, 0, 1);
        for (int i = 0; i < 5; i++) begin win_game(1); win_game(0); end
        checks++; if (games_a !== 3'd5 || games_b !== 3'd5 || set_done !== 1'b0) begin
            failures++; $display("FAIL s75_55 games=%0d/%0d done=%b want=5/5 0", games_a, games_b, set_done); end
        win_game(1);
        checks++; if (games_a !== 3'd6 || set_done !== 1'b0) begin
            failures++; $display("FAIL s75_65 games_a=%0d done=%b want=6 0", games_a, set_done); end
        win_game(1);
        checks++; if (games_a !== 3'd7 || games_b !== 3'd5 || set_done !== 1'b1 || set_winner !== 1'b0 || game_a !== 1'b1) begin
            failures++; $display("FAIL s75_win games=%0d/%0d done=%b winner=%b game_a=%b want=7/5 1 0 1", games_a, games_b, set_done, set_winner, game_a); end
        drive(1, 0, 0); drive(0, 1, 0); drive(1, 1, 0); drive(0, 1, 0);
        checks++; if ({score_a, score_b, games_a, games_b} !== {3'd0, 3'd0, 3'd7, 3'd5} ||
                      {set_done, set_winner, game_a, game_b, collision, deuce} !== 6'b100000) begin
            failures++; $display("FAIL s75_hold s=%0d/%0d g=%0d/%0d flags=%b want 0/0 7/5 100000", score_a, score_b, games_a, games_b,
                                 {set_done, set_winner, game_a, game_b, collision, deuce}); end
    endtask

    task automatic test_set_7_6();
        drive(0, 0, 1);
        checks++; if (set_done !== 1'b0 || games_a !== 3'd0) begin
            failures++; $display("FAIL s76_newset done=%b games_a=%0d want=0 0", set_done, games_a); end
        for (int i = 0; i < 6; i++) begin win_game(1); win_game(0); end
        checks++; if (games_a !== 3'd6 || games_b !== 3'd6 || set_done !== 1'b0) begin
            failures++; $display("FAIL s76_66 games=%0d/%0d done=%b want=6/6 0", games_a, games_b, set_done); end
        win_game(1);
        checks++; if (games_a !== 3'd7 || games_b !== 3'd6 || set_done !== 1'b1 || set_winner !== 1'b0) begin
            failures++; $display("FAIL s76_win games=%0d/%0d done=%b winner=%b want=7/6 1 0", games_a, games_b, set_done, set_winner); end
    endtask

    task automatic test_set_b_love();
        drive(0, 0, 1);
        for (int i = 0; i < 5; i++) win_game(0);
        checks++; if (games_b !== 3'd5 || set_done !== 1'b0) begin
            failures++; $display("FAIL sb_05 games_b=%0d done=%b want=5 0", games_b, set_done); end
        win_game(0);
        checks++; if (games_a !== 3'd0 || games_b !== 3'd6 || set_done !== 1'b1 || set_winner !== 1'b1) begin
            failures++; $display("FAIL sb_win games=%0d/%0d done=%b winner=%b want=0/6 1 1", games_a, games_b, set_done, set_winner); end
    endtask

    task automatic test_collision();
        drive(0, 0, 1);
        drive(1, 0, 0); drive(1, 0, 0); drive(0, 1, 0);
        drive(1, 1, 0);
        checks++; if (collision !== 1'b1 || score_a !== 3'd2 || score_b !== 3'd1) begin
            failures++; $display("FAIL coll_pulse coll=%b scores=%0d/%0d want=1 2/1", collision, score_a, score_b); end
        drive(0, 0, 0);
        checks++; if (collision !== 1'b0 || score_a !== 3'd2 || score_b !== 3'd1) begin
            failures++; $display("FAIL coll_end coll=%b scores=%0d/%0d want=0 2/1", collision, score_a, score_b); end
        drive(0, 1, 1);
        checks++; if ({score_a, score_b, games_a, games_b} !== 12'd0 || collision !== 1'b0 || game_b !== 1'b0) begin
            failures++; $display("FAIL coll_newset scores=%0d/%0d coll=%b want=0/0 0", score_a, score_b, collision); end
        drive(1, 1, 1);
        checks++; if (collision !== 1'b0 || score_a !== 3'd0) begin
            failures++; $display("FAIL coll_newset_both coll=%b score_a=%0d want=0 0", collision, score_a); end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 1);
        win_game(0);
        repeat (3) drive(0, 1, 0);
        repeat (3) drive(1, 0, 0);
        drive(0, 1, 0);
        checks++; if (score_a !== 3'd3 || score_b !== 3'd4 || games_b !== 3'd1) begin
            failures++; $display("FAIL ar_setup scores=%0d/%0d games_b=%0d want=3/4 1", score_a, score_b, games_b); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({score_a, score_b, games_a, games_b} !== 12'd0 ||
                      {deuce, game_a, game_b, set_done, set_winner, collision} !== 6'b0) begin
            failures++; $display("FAIL ar_immediate scores=%0d/%0d games=%0d/%0d flags=%b want all 0", score_a, score_b, games_a, games_b,
                                 {deuce, game_a, game_b, set_done, set_winner, collision}); end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0);
        checks++; if (score_a !== 3'd1 || score_b !== 3'd0 || games_b !== 3'd0) begin
            failures++; $display("FAIL ar_first_pt scores=%0d/%0d games_b=%0d want=1/0 0", score_a, score_b, games_b); end
    endtask

    task automatic test_random();
        int r;
        bit a, b, n;
        int shown = 0;
        drive(0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            a = (r < 90) || (r >= 180 && r < 188);
            b = (r >= 90 && r < 180) || (r >= 180 && r < 188);
            n = (r >= 197);
            if (r == 199) a = 1'b1;
            drive(a, b, n);
            checks++;
            if (score_a !== 3'(code_of(m_na, m_nb)) || score_b !== 3'(code_of(m_nb, m_na)) ||
                games_a !== 3'(m_ga) || games_b !== 3'(m_gb) ||
                deuce !== (code_of(m_na, m_nb) == 3 && code_of(m_nb, m_na) == 3) ||
                game_a !== m_pa || game_b !== m_pb || set_done !== m_over || collision !== m_coll ||
                (m_over && set_winner !== m_win)) begin
                failures++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_cyc%0d got s=%0d/%0d g=%0d/%0d d=%b ga=%b gb=%b done=%b w=%b c=%b want s=%0d/%0d g=%0d/%0d ga=%b gb=%b done=%b w=%b c=%b",
                             i, score_a, score_b, games_a, games_b, deuce, game_a, game_b, set_done, set_winner, collision,
                             code_of(m_na, m_nb), code_of(m_nb, m_na), m_ga, m_gb, m_pa, m_pb, m_over, m_win, m_coll);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_game();
        test_deuce();
        test_set_7_5();
        test_set_7_6();
        test_set_b_love();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
